// File: rtl/slt_arbiter.sv
// Round-robin arbiter that time-shares one signed 32-bit set-less-than unit
// among N_REQ requesters, returning a tagged 0/1 result over valid/ready.

module slt_32_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        lt
);
    assign lt = ($signed(a) < $signed(b));
endmodule

module slt_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ-1:0]       req_unsigned,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_result,
    output logic                   busy
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Flipping the sign bit maps unsigned order onto signed order.
    function automatic logic [WIDTH-1:0] bias_op(input logic [WIDTH-1:0] v, input logic uns);
        logic [WIDTH-1:0] r;
        if (uns) begin
            r = {~v[WIDTH-1], v[WIDTH-2:0]};
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t            state_r, state_next_s;
    logic [ID_W-1:0]   ptr_r, id_r, grant_s, next_ptr_s;
    logic [ID_W:0]     cand_s;
    logic              found_s, hs_s, lt_s, busy_r, rsp_valid_r;
    logic [WIDTH-1:0]  op_a_r, op_b_r, sel_a_s, sel_b_s, rsp_result_r;
    logic [ID_W-1:0]   rsp_id_r;
    logic [N_REQ-1:0]  ready_s;

    // Rotating priority scan starting at ptr_r, wrapping at N_REQ.
    always_comb begin
        found_s = 1'b0;
        grant_s = '0;
        cand_s  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_s = {1'b0, ptr_r} + (ID_W+1)'(k);
            if (cand_s >= (ID_W+1)'(N_REQ)) begin
                cand_s = cand_s - (ID_W+1)'(N_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && req_valid[cand_s[ID_W-1:0]]) begin
                found_s = 1'b1;
                grant_s = cand_s[ID_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Grant strobe, operand mux and pointer advance for the winning requester.
    always_comb begin
        ready_s    = '0;
        hs_s       = 1'b0;
        sel_a_s    = req_a[int'(grant_s)*WIDTH +: WIDTH];
        sel_b_s    = req_b[int'(grant_s)*WIDTH +: WIDTH];
        next_ptr_s = grant_s + ID_W'(1);
        if (grant_s == ID_W'(N_REQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_s + ID_W'(1);
        end
        if (rst_n && (state_r == ST_IDLE) && found_s) begin
            ready_s[grant_s] = 1'b1;
            hs_s             = 1'b1;
        end else begin
            ready_s = '0;
            hs_s    = 1'b0;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (hs_s) begin
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: state_next_s = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    slt_32_bit u_slt (
        .a  (op_a_r),
        .b  (op_b_r),
        .lt (lt_s)
    );

    // Operand capture, response registers and registered busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r        <= '0;
            id_r         <= '0;
            op_a_r       <= '0;
            op_b_r       <= '0;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= '0;
            rsp_result_r <= '0;
            busy_r       <= 1'b0;
        end else begin
            if (hs_s) begin
                op_a_r <= bias_op(sel_a_s, req_unsigned[grant_s]);
                op_b_r <= bias_op(sel_b_s, req_unsigned[grant_s]);
                id_r   <= grant_s;
                ptr_r  <= next_ptr_s;
            end
            if (state_r == ST_EXEC) begin
                rsp_result_r <= {{(WIDTH-1){1'b0}}, lt_s};
                rsp_id_r     <= id_r;
                rsp_valid_r  <= 1'b1;
            end else if ((state_r == ST_RESP) && rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end
            busy_r <= (state_next_s != ST_IDLE);
        end
    end

    assign req_ready  = ready_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_result = rsp_result_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_slt_arbiter.sv
// Directed self-checking bench for slt_arbiter: compare results, round-robin
// order, pointer wrap, backpressure and asynchronous reset behaviour.

module tb_slt_arbiter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid, req_ready, req_unsigned;
    logic [127:0] req_a, req_b;
    logic         rsp_valid, rsp_ready, busy;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_result;
    int           pass_cnt = 0;
    int           total_cnt = 0;

    always #5 clk = ~clk;

    slt_arbiter #(.N_REQ(4), .WIDTH(32), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .busy(busy)
    );

    // One full transaction on requester i; returns what was observed.
    task automatic do_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic u,
                          output logic [1:0] id, output logic [31:0] res,
                          output logic [3:0] rdy, output logic [3:0] seq);
        @(negedge clk);
        req_valid = 4'b0000;
        req_valid[i] = 1'b1;
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_unsigned[i] = u;
        rsp_ready = 1'b1;
        #1 rdy = req_ready;
        @(negedge clk);
        req_valid = 4'b0000;
        seq[0] = rsp_valid;
        seq[1] = busy;
        @(negedge clk);
        seq[2] = rsp_valid;
        id = rsp_id;
        res = rsp_result;
        @(negedge clk);
        seq[3] = rsp_valid | busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 4'hF; req_unsigned = 4'h0;
        req_a = 128'd0; req_b = 128'd0; rsp_ready = 1'b0;
        #3;
        total_cnt++; if (req_ready !== 4'h0) $display("FAIL rst_ready: got %h expected 0", req_ready); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (rsp_id !== 2'd0) $display("FAIL rst_id: got %0d expected 0", rsp_id); else pass_cnt++;
        total_cnt++; if (rsp_result !== 32'd0) $display("FAIL rst_result: got %h expected 0", rsp_result); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'h0;
    endtask

    task automatic test_compare();
        logic [31:0] va [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd8, 32'd128, 32'd0,
                                32'h8000_0000, 32'h8000_0000, 32'd5};
        logic [31:0] vb [8] = '{32'd6, 32'd6, 32'd48, 32'd64, 32'd0,
                                32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd5};
        logic        vu [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ve [8] = '{32'd1, 32'd0, 32'd1, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0};
        logic [1:0]  id;
        logic [31:0] res;
        logic [3:0]  rdy, seq;
        for (int v = 0; v < 8; v++) begin
            do_req(0, va[v], vb[v], vu[v], id, res, rdy, seq);
            total_cnt++; if (rdy !== 4'b0001) $display("FAIL cmp%0d_ready: got %h expected 1", v, rdy); else pass_cnt++;
            total_cnt++; if (seq !== 4'b0110) $display("FAIL cmp%0d_timing: got %b expected 0110", v, seq); else pass_cnt++;
            total_cnt++; if (id !== 2'd0) $display("FAIL cmp%0d_id: got %0d expected 0", v, id); else pass_cnt++;
            total_cnt++; if (res !== ve[v]) $display("FAIL cmp%0d_result: got %h expected %h", v, res, ve[v]); else pass_cnt++;
        end
    endtask

    // 12 consecutive cycles: four grants, each 3 cycles apart, in the given order.
    task automatic run_rr(input logic [3:0] mask, input logic [7:0] order);
        int          k;
        logic [1:0]  g;
        logic [3:0]  exp_rdy;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            req_valid = mask;
            #1;
            k = c / 3;
            g = order[2*k +: 2];
            exp_rdy = (c % 3 == 0) ? (4'b0001 << g) : 4'b0000;
            total_cnt++; if (req_ready !== exp_rdy) $display("FAIL rr_c%0d_ready: got %h expected %h", c, req_ready, exp_rdy); else pass_cnt++;
            total_cnt++; if (rsp_valid !== (c % 3 == 2)) $display("FAIL rr_c%0d_valid: got %b expected %b", c, rsp_valid, (c % 3 == 2)); else pass_cnt++;
            if (c % 3 == 2) begin
                total_cnt++; if (rsp_id !== g) $display("FAIL rr_c%0d_id: got %0d expected %0d", c, rsp_id, g); else pass_cnt++;
                total_cnt++; if (rsp_result !== ((g < 2'd2) ? 32'd1 : 32'd0)) $display("FAIL rr_c%0d_result: got %h expected %0d", c, rsp_result, (g < 2'd2)); else pass_cnt++;
            end
        end
    endtask

    task automatic test_round_robin();
        @(negedge clk);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = 32'(i);
            req_b[i*32 +: 32] = 32'd2;
        end
        req_unsigned = 4'h0;
        rsp_ready = 1'b1;
        run_rr(4'hF, {2'd3, 2'd2, 2'd1, 2'd0});
        run_rr(4'b1101, {2'd0, 2'd3, 2'd2, 2'd0});
        @(negedge clk);
        req_valid = 4'h0;
    endtask

    task automatic test_pointer_wrap();
        logic [1:0]  id;
        logic [31:0] res;
        logic [3:0]  rdy, seq;
        do_req(3, 32'd9, 32'd1, 1'b0, id, res, rdy, seq);
        total_cnt++; if (rdy !== 4'b1000) $display("FAIL wrap_first_ready: got %h expected 8", rdy); else pass_cnt++;
        total_cnt++; if (res !== 32'd0) $display("FAIL wrap_first_result: got %h expected 0", res); else pass_cnt++;
        @(negedge clk);
        req_valid = 4'b0101;
        #1;
        total_cnt++; if (req_ready !== 4'b0001) $display("FAIL wrap_ready0: got %h expected 1", req_ready); else pass_cnt++;
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        total_cnt++; if (rsp_id !== 2'd0) $display("FAIL wrap_id0: got %0d expected 0", rsp_id); else pass_cnt++;
        @(negedge clk);
        req_valid = 4'b0101;
        #1;
        total_cnt++; if (req_ready !== 4'b0100) $display("FAIL wrap_ready2: got %h expected 4", req_ready); else pass_cnt++;
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        total_cnt++; if (rsp_id !== 2'd2) $display("FAIL wrap_id2: got %0d expected 2", rsp_id); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL wrap_idle_busy: got %b expected 0", busy); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        req_a[32 +: 32] = 32'd5;
        req_b[32 +: 32] = 32'd9;
        req_unsigned = 4'h0;
        @(negedge clk);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1;
        total_cnt++; if (req_ready !== 4'b0010) $display("FAIL bp_grant: got %h expected 2", req_ready); else pass_cnt++;
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        req_valid = 4'hF;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL bp_c%0d_valid: got %b expected 1", c, rsp_valid); else pass_cnt++;
            total_cnt++; if (rsp_id !== 2'd1) $display("FAIL bp_c%0d_id: got %0d expected 1", c, rsp_id); else pass_cnt++;
            total_cnt++; if (rsp_result !== 32'd1) $display("FAIL bp_c%0d_result: got %h expected 1", c, rsp_result); else pass_cnt++;
            total_cnt++; if (req_ready !== 4'h0) $display("FAIL bp_c%0d_ready: got %h expected 0", c, req_ready); else pass_cnt++;
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        total_cnt++; if (req_ready !== 4'h0) $display("FAIL bp_release_ready: got %h expected 0", req_ready); else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL bp_after_valid: got %b expected 0", rsp_valid); else pass_cnt++;
        total_cnt++; if (req_ready !== 4'b0100) $display("FAIL bp_after_grant: got %h expected 4", req_ready); else pass_cnt++;
        req_valid = 4'h0;
    endtask

    task automatic test_reset_exec();
        @(negedge clk);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        total_cnt++; if (req_ready !== 4'b0100) $display("FAIL rexec_grant: got %h expected 4", req_ready); else pass_cnt++;
        @(negedge clk);
        req_valid = 4'h0;
        #1;
        total_cnt++; if (busy !== 1'b1) $display("FAIL rexec_busy_before: got %b expected 1", busy); else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rexec_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rexec_valid: got %b expected 0", rsp_valid); else pass_cnt++;
        req_valid = 4'hF;
        #1;
        total_cnt++; if (req_ready !== 4'h0) $display("FAIL rexec_ready_in_reset: got %h expected 0", req_ready); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'h0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rexec_c%0d_no_rsp: got %b expected 0", c, rsp_valid); else pass_cnt++;
        end
        @(negedge clk);
        req_valid = 4'b1010;
        #1;
        total_cnt++; if (req_ready !== 4'b0010) $display("FAIL rexec_next_grant: got %h expected 2", req_ready); else pass_cnt++;
        @(negedge clk);
        req_valid = 4'h0;
    endtask

    task automatic test_reset_resp();
        rsp_ready = 1'b0;
        @(negedge clk);
        #1;
        total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL rresp_valid_before: got %b expected 1", rsp_valid); else pass_cnt++;
        total_cnt++; if (rsp_result !== 32'd1) $display("FAIL rresp_result_before: got %h expected 1", rsp_result); else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rresp_valid: got %b expected 0", rsp_valid); else pass_cnt++;
        total_cnt++; if (rsp_result !== 32'd0) $display("FAIL rresp_result: got %h expected 0", rsp_result); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rresp_busy: got %b expected 0", busy); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rresp_after: got %b expected 0", rsp_valid); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_compare();
        test_round_robin();
        test_pointer_wrap();
        test_backpressure();
        test_reset_exec();
        test_reset_resp();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/slt_arbiter.md
# slt_arbiter

Round-robin arbiter and sequencer that shares one 32-bit set-less-than unit (`slt_32_bit`) among several requesters, such as the decode/execute stage and a branch-compare helper. Each requester presents an operand pair over a valid/ready handshake. The block grants one requester at a time, drives the registered operands through the shared comparator, and returns a tagged 32-bit result (0 or 1) over a second valid/ready handshake. An optional per-request unsigned flag turns the signed comparator into an SLTU by biasing both operands.

## Interface
- `N_REQ`, default 4: number of requesters, range 2..8.
- `WIDTH`, default 32: operand and result width. The shared `slt_32_bit` instance fixes this at 32.
- `ID_W`, default 2: width of the requester tag. Must equal clog2(`N_REQ`).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester accept strobe; at most one bit is high.
- `req_a`  in  N_REQ*WIDTH  operand A, packed; requester i uses bits [i*WIDTH +: WIDTH].
- `req_b`  in  N_REQ*WIDTH  operand B, packed the same way.
- `req_unsigned`  in  N_REQ  1 selects SLTU, 0 selects SLT.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  ID_W  index of the requester the result belongs to.
- `rsp_result`  out  WIDTH  32'd1 if A<B, else 32'd0.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM has three states: IDLE, EXEC, RESP. The state is registered.
- IDLE:
  - If any `req_valid` bit is high, pick winner g by scanning from `ptr` upward with wrap-around (ptr, ptr+1, …, N_REQ-1, 0, …).
  - `req_ready[g]`=1 combinationally in the same cycle. A handshake occurs when both valid and ready are high.
  - On the handshake edge:
    - `op_a`/`op_b` capture the requester's operands. If `req_unsigned[g]`=1, both are stored with bit 31 inverted.
    - `id_q` <= g.
    - `ptr` <= (g+1) mod N_REQ.
    - Next state is EXEC.
  - If no request is valid, stay in IDLE and leave `ptr` unchanged.
- EXEC:
  - The shared `slt_32_bit` takes `op_a`, `op_b` and produces its result combinationally.
  - On the edge: `rsp_result` <= comparator output, `rsp_id` <= `id_q`, `rsp_valid` <= 1, next state is RESP.
- RESP:
  - Hold `rsp_valid`, `rsp_id` and `rsp_result` stable until `rsp_ready`=1.
  - On the handshake edge: `rsp_valid` <= 0, next state is IDLE.
- `req_ready` is all-zero in EXEC and RESP.
- Requests left pending keep their `valid` asserted. The arbiter does not latch them.
- Arithmetic:
  - Signed: two's-complement comparison of A and B.
  - Unsigned: the bias A^32'h8000_0000 < B^32'h8000_0000 under a signed compare equals an unsigned A<B.
  - Equal operands give 0.
- Simultaneous events:
  - A requester that drops `req_valid` before it is granted is simply skipped.
  - `rsp_ready` high while `rsp_valid`=0 is ignored.

## Timing
- Reset (`rst_n`=0) is asynchronous and immediate. It sets:
  - state=IDLE, `ptr`=0;
  - `op_a`=`op_b`=0, `id_q`=0;
  - `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0;
  - `busy`=0.
  - `req_ready` is combinational, so it is 0 while reset is held.
- Reset mid-operation, in EXEC or RESP: the in-flight request is discarded and no response is produced. The requester has already been handshaked and must reissue.
- Latency:
  - Request handshake at edge T.
  - `rsp_valid` rises after edge T+1 (EXEC→RESP).
  - Earliest response handshake is at edge T+2.
  - Earliest next grant is in the cycle after that, so minimum spacing is 3 cycles per request.
- Backpressure: RESP waits indefinitely and the outputs are stable throughout.
- `busy` is a registered decode of the state, not combinational off the inputs.

## Test plan
- Signed compare. Request on requester 0: A=-7 (32'hFFFF_FFF9), B=6, unsigned=0. Expect `rsp_result`=1, `rsp_id`=0, `rsp_valid` high 2 edges after the grant.
- Unsigned flag. Same operands, unsigned=1. Expect `rsp_result`=0. Then A=8, B=48 gives 1; A=128, B=64 gives 0; A=B=0 gives 0.
- Round-robin fairness. All four requesters hold valid continuously with `rsp_ready`=1. Expect grant and `rsp_id` order 0,1,2,3,0,… with one grant every 3 cycles. Then drop requester 1: order becomes 0,2,3,0.
- Pointer wrap. After a grant to requester 3, only requesters 0 and 2 are valid. Expect requester 0 granted first.
- Backpressure. Hold `rsp_ready`=0 for 10 cycles during RESP. Expect `rsp_valid`, `rsp_id` and `rsp_result` stable, `req_ready`=0 throughout, and no new grant until one cycle after `rsp_ready` rises.
- Async reset in EXEC. Assert `rst_n`=0 mid-cycle. Expect `rsp_valid`=0 and `busy`=0 immediately, no response after release, and the next grant going to the lowest valid index (`ptr`=0).
